// File: rtl/ioctl_loader.sv
// ioctl download initiator: streams bytes from a valid/ready source into a core's ROM-load port.
// Optional: define IOCTL_LOADER_CHECKSUM_EN to accumulate a 16-bit additive checksum of written bytes.
`timescale 1ns/1ps
module ioctl_loader #(
    parameter int LEAD_CYCLES = 4,   // must be >= 1
    parameter int GAP_CYCLES  = 2
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  index,
    input  logic [24:0] length,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        busy,
    output logic        done,
    output logic [15:0] checksum,
    output logic        ioctl_download,
    output logic        ioctl_wr,
    output logic [24:0] ioctl_addr,
    output logic [7:0]  ioctl_dout,
    output logic [7:0]  ioctl_index,
    input  logic        ioctl_wait
);
    typedef enum logic [2:0] {IDLE, LEAD, FETCH, WRITE, GAP, TAIL} state_e;

    localparam logic [15:0] LEAD_LAST = 16'(LEAD_CYCLES - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);

    state_e      state_q;
    logic [15:0] cnt_q;
    logic [24:0] remain_q, addr_cnt_q, addr_q;
    logic [7:0]  dout_q, index_q;
    logic        download_q, wr_q, busy_q, done_q;
    logic        hs;

    // Back-pressure is the only combinational path to an output.
    assign s_ready = (state_q == FETCH) && !ioctl_wait;
    assign hs      = s_ready && s_valid;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            remain_q   <= '0;
            addr_cnt_q <= '0;
            addr_q     <= '0;
            dout_q     <= '0;
            index_q    <= '0;
            download_q <= 1'b0;
            wr_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (start) begin
                        index_q    <= index;
                        remain_q   <= length;
                        addr_cnt_q <= '0;
                        cnt_q      <= '0;
                        download_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= LEAD;
                    end
                end
                LEAD: begin
                    if (cnt_q == LEAD_LAST) begin
                        cnt_q   <= '0;
                        state_q <= (remain_q == '0) ? TAIL : FETCH;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                FETCH: begin
                    if (hs) begin
                        dout_q   <= s_data;
                        addr_q   <= addr_cnt_q;
                        wr_q     <= 1'b1;
                        remain_q <= remain_q - 25'd1;
                        state_q  <= WRITE;
                    end
                end
                WRITE: begin
                    wr_q       <= 1'b0;
                    addr_cnt_q <= addr_cnt_q + 25'd1;
                    cnt_q      <= '0;
                    if (GAP_CYCLES == 0)
                        state_q <= (remain_q == '0) ? TAIL : FETCH;
                    else
                        state_q <= GAP;
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q   <= '0;
                        state_q <= (remain_q == '0) ? TAIL : FETCH;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                TAIL: begin
                    if (cnt_q == LEAD_LAST) begin
                        download_q <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef IOCTL_LOADER_CHECKSUM_EN
    logic [15:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (state_q == IDLE && start)
            csum_d = '0;
        else if (state_q == WRITE)
            csum_d = csum_q + {8'h00, dout_q};
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) csum_q <= '0;
        else          csum_q <= csum_d;
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

    assign busy           = busy_q;
    assign done           = done_q;
    assign ioctl_download = download_q;
    assign ioctl_wr       = wr_q;
    assign ioctl_addr     = addr_q;
    assign ioctl_dout     = dout_q;
    assign ioctl_index    = index_q;
endmodule

// File: tb/tb_ioctl_loader.sv
// Bench for ioctl_loader: a timeline model (cycle arithmetic from the protocol timing rules) checked
// every cycle, plus hand-computed literal expectations per scenario.
`timescale 1ns/1ps
module tb_ioctl_loader;
    localparam int LEAD = 4;
    localparam int GAP  = 2;
    localparam int BIG  = 1 << 30;
`ifdef IOCTL_LOADER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic        clk_sys = 1'b0, reset_n = 1'b0, start = 1'b0, ioctl_wait = 1'b0;
    logic [7:0]  index = '0;
    logic [24:0] length = '0;
    logic [7:0]  s_data;
    logic        s_valid, s_ready, busy, done, ioctl_download, ioctl_wr;
    logic [15:0] checksum;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout, ioctl_index;

    ioctl_loader #(.LEAD_CYCLES(LEAD), .GAP_CYCLES(GAP)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .start(start), .index(index), .length(length),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .busy(busy), .done(done),
        .checksum(checksum), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
        .ioctl_wait(ioctl_wait)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    // Byte source: hs_cnt counts accepted bytes, base marks the start of the loaded image.
    logic [7:0] strm [16];
    int  hs_cnt = 0, base = 0, slen = 0;
    bit  valid_en = 1'b1;
    always @(posedge clk_sys) if (s_valid && s_ready) hs_cnt <= hs_cnt + 1;
    assign s_data  = strm[4'(hs_cnt - base)];
    assign s_valid = valid_en && ((hs_cnt - base) < slen);

    int tests = 0, fails = 0;
    bit chk_en = 1'b0;

    // timeline model state
    bit          act = 1'b0;
    int          S = 0, done_cyc = BIG, wr_cyc = -1, nf = BIG, left = 0;
    logic [24:0] m_addr = '0, pend_addr = '0, next_addr = '0;
    logic [7:0]  m_dout = '0, pend_dout = '0, m_idx = '0;
    logic [15:0] m_sum = '0;
    // observation logs since the last accepted start
    int wr_rel[$], wr_addr[$], wr_dout[$];
    int ndone = 0, done_rel = -1;
    // literal expectation requests from the stimulus
    int lit_req = 0, lit_seen = 0;
    int lw[$], la[$], ld[$];
    int l_done = -1, l_sum = 0, l_idx = 0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, a, e);
        end
    endtask

    always @(negedge clk_sys) begin
        if (chk_en) begin
            bit e_busy, e_dl, e_done, e_wr, e_rdy;
            if (cyc == wr_cyc) begin
                m_addr = pend_addr;
                m_dout = pend_dout;
                m_sum  = m_sum + 16'(pend_dout);
            end
            e_busy = act && cyc > S && cyc <= done_cyc;
            e_dl   = act && cyc > S && cyc < done_cyc;
            e_done = act && cyc == done_cyc;
            e_wr   = (cyc == wr_cyc);
            e_rdy  = act && left > 0 && cyc >= nf && !ioctl_wait;
            chk("busy", 32'(busy), 32'(e_busy));
            chk("download", 32'(ioctl_download), 32'(e_dl));
            chk("done", 32'(done), 32'(e_done));
            chk("wr", 32'(ioctl_wr), 32'(e_wr));
            chk("s_ready", 32'(s_ready), 32'(e_rdy));
            chk("addr", 32'(ioctl_addr), 32'(m_addr));
            chk("dout", 32'(ioctl_dout), 32'(m_dout));
            chk("index", 32'(ioctl_index), 32'(m_idx));
            if (!act || cyc >= done_cyc)
                chk("checksum", 32'(checksum), CSUM ? 32'(m_sum) : 32'd0);

            if (ioctl_wr === 1'b1) begin
                wr_rel.push_back(cyc - S);
                wr_addr.push_back(int'(ioctl_addr));
                wr_dout.push_back(int'(ioctl_dout));
            end
            if (done === 1'b1) begin
                ndone++;
                done_rel = cyc - S;
            end

            if (lit_req != lit_seen) begin
                lit_seen = lit_req;
                chk("lit_nwr", 32'(wr_rel.size()), 32'(lw.size()));
                foreach (lw[i]) if (i < wr_rel.size()) begin
                    chk("lit_wr_cycle", 32'(wr_rel[i]), 32'(lw[i]));
                    chk("lit_wr_addr", 32'(wr_addr[i]), 32'(la[i]));
                    chk("lit_wr_dout", 32'(wr_dout[i]), 32'(ld[i]));
                end
                chk("lit_ndone", 32'(ndone), (l_done < 0) ? 32'd0 : 32'd1);
                if (l_done >= 0) chk("lit_done_cycle", 32'(done_rel), 32'(l_done));
                chk("lit_index", 32'(ioctl_index), 32'(l_idx));
                chk("lit_checksum", 32'(checksum), CSUM ? 32'(l_sum) : 32'd0);
            end

            if (!reset_n) begin
                act = 1'b0; wr_cyc = -1; done_cyc = BIG; left = 0;
                m_addr = '0; m_dout = '0; m_idx = '0; m_sum = '0;
            end else begin
                if (e_rdy && s_valid === 1'b1) begin
                    pend_addr = next_addr;
                    next_addr = next_addr + 25'd1;
                    pend_dout = s_data;
                    wr_cyc    = cyc + 1;
                    nf        = cyc + 2 + GAP;
                    left--;
                    if (left == 0) done_cyc = cyc + 2 + GAP + LEAD;
                end
                if (start === 1'b1 && (!act || cyc >= done_cyc)) begin
                    act = 1'b1; S = cyc; m_idx = index; m_sum = '0; next_addr = '0;
                    left = int'(length); nf = cyc + 1 + LEAD; wr_cyc = -1;
                    done_cyc = (length == '0) ? cyc + 1 + 2 * LEAD : BIG;
                    wr_rel.delete(); wr_addr.delete(); wr_dout.delete();
                    ndone = 0; done_rel = -1;
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic load(input int n, input logic [47:0] bytes);
        for (int i = 0; i < n; i++) strm[i] = bytes[8*i +: 8];
        slen = n;
        base = hs_cnt;
    endtask

    task automatic do_start(input logic [7:0] idx, input logic [24:0] len);
        index = idx; length = len; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300 && ndone == 0; i++) tick();
        tick(2);
    endtask

    task automatic ew(input int rel, input int addr, input int dat);
        lw.push_back(rel); la.push_back(addr); ld.push_back(dat);
    endtask

    task automatic lit_check(input int dn, input int sum, input int idx);
        l_done = dn; l_sum = sum; l_idx = idx;
        lit_req++;
        tick();
        lw.delete(); la.delete(); ld.delete();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) strm[i] = '0;
        tick(3);
        chk_en = 1'b1;
        tick();
        reset_n = 1'b1;
        tick(2);

        // basic 4-byte transfer, free-flowing stream
        load(4, 48'h0000_4433_2211);
        do_start(8'h01, 25'd4);
        wait_done();
        ew(6, 0, 'h11); ew(10, 1, 'h22); ew(14, 2, 'h33); ew(18, 3, 'h44);
        lit_check(25, 'h00AA, 'h01);

        // zero-length transfer
        do_start(8'h05, 25'd0);
        wait_done();
        lit_check(9, 0, 'h05);

        // core stall for 10 cycles while fetching
        load(2, 48'h0000_0000_5AA5);
        do_start(8'h02, 25'd2);
        tick(4);
        ioctl_wait = 1'b1;
        tick(10);
        ioctl_wait = 1'b0;
        wait_done();
        ew(16, 0, 'hA5); ew(20, 1, 'h5A);
        lit_check(27, 'h00FF, 'h02);

        // source starves for 7 cycles mid-transfer
        load(4, 48'h0000_0403_0201);
        do_start(8'h03, 25'd4);
        tick(5);
        valid_en = 1'b0;
        tick(7);
        valid_en = 1'b1;
        wait_done();
        ew(6, 0, 'h01); ew(14, 1, 'h02); ew(18, 2, 'h03); ew(22, 3, 'h04);
        lit_check(29, 'h000A, 'h03);

        // reset in the gap after byte 2 of 6, then a fresh transfer
        load(6, 48'h6655_4433_2211);
        do_start(8'h33, 25'd6);
        tick(10);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick(4);
        ew(6, 0, 'h11); ew(10, 1, 'h22);
        lit_check(-1, 0, 'h00);
        load(2, 48'h0000_0000_BC9A);
        do_start(8'h44, 25'd2);
        wait_done();
        ew(6, 0, 'h9A); ew(10, 1, 'hBC);
        lit_check(17, 'h0156, 'h44);

        // start re-pulsed while busy must be ignored
        load(3, 48'h0000_0030_2010);
        do_start(8'h0A, 25'd3);
        tick(2);
        do_start(8'h77, 25'd9);
        tick(3);
        do_start(8'h77, 25'd9);
        wait_done();
        tick(6);
        ew(6, 0, 'h10); ew(10, 1, 'h20); ew(14, 2, 'h30);
        lit_check(21, 'h0060, 'h0A);

        tick(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
